// File: rtl/riscv_muldiv_unit_if.sv
// Operand/result handshake bundle between the execute stage and the M-extension unit.
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            busy;

    modport master (
        output in_valid, funct3, op_a, op_b, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  in_valid, funct3, op_a, op_b, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// RV M-extension multiply/divide unit with valid/ready handshake and flush.
// Signed ops run on magnitudes through one shared iterative core; the sign is applied on entry to DONE.
module riscv_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    riscv_muldiv_unit_if.slave md_if
);
    localparam int CNT_W = ($clog2(XLEN) + 1 > 5) ? $clog2(XLEN) + 1 : 5;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [4:0]        tag_q, tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              a_signed, b_signed, a_neg, b_neg, in_neg;
    logic              is_div, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;

    // For multiplies raw is the full product; for divides it is {remainder, quotient}.
    function automatic logic [XLEN-1:0] fix_result(input logic [2:0] f, input logic neg,
                                                   input logic [2*XLEN-1:0] raw);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg ? -raw : raw;
        quo  = neg ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        rem  = neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        if (!f[2]) begin
            fix_result = (f[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fix_result = f[1] ? rem : quo;
        end
    endfunction

    always_comb begin
        is_div    = md_if.funct3[2];
        a_signed  = (md_if.funct3 != 3'b011) && (md_if.funct3 != 3'b101) && (md_if.funct3 != 3'b111);
        b_signed  = (md_if.funct3[2:1] == 2'b00) || (md_if.funct3[2] && !md_if.funct3[0]);
        a_neg     = a_signed && md_if.op_a[XLEN-1];
        b_neg     = b_signed && md_if.op_b[XLEN-1];
        mag_a     = a_neg ? -md_if.op_a : md_if.op_a;
        mag_b     = b_neg ? -md_if.op_b : md_if.op_b;
        in_neg    = (md_if.funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
        div_zero  = is_div && (md_if.op_b == '0);
        div_ovf   = is_div && !md_if.funct3[0] && (md_if.op_a == MIN_INT) && (md_if.op_b == '1);
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    end

    // One shift-add or one restoring-divide step per CALC cycle.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q, 1'b0};
        div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, b_q};
        if (op_q[2]) begin
            acc_step = div_diff[XLEN] ? div_shift[2*XLEN-1:0]
                                      : {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_if.in_valid) begin
                        op_d  = md_if.funct3;
                        tag_d = md_if.rd_in;
                        neg_d = in_neg;
                        cnt_d = '0;
                        if (div_zero) begin
                            state_d  = DONE;
                            result_d = md_if.funct3[1] ? md_if.op_a : '1;
                            rd_out_d = md_if.rd_in;
                        end else if (div_ovf) begin
                            state_d  = DONE;
                            result_d = md_if.funct3[1] ? '0 : md_if.op_a;
                            rd_out_d = md_if.rd_in;
                        end else if (FAST_MUL && !is_div) begin
                            state_d  = DONE;
                            result_d = fix_result(md_if.funct3, in_neg, fast_prod);
                            rd_out_d = md_if.rd_in;
                        end else begin
                            state_d = CALC;
                            acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                            b_d     = is_div ? mag_b : mag_a;
                        end
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d  = DONE;
                        result_d = fix_result(op_q, neg_q, acc_step);
                        rd_out_d = tag_q;
                    end
                end
                DONE: begin
                    if (md_if.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign md_if.in_ready  = (state_q == IDLE) && !rst_i;
    assign md_if.out_valid = (state_q == DONE);
    assign md_if.busy      = (state_q == CALC) || (state_q == DONE);
    assign md_if.result    = result_q;
    assign md_if.rd_out    = rd_out_q;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: a 32-bit fast-multiply instance and a 16-bit fully iterative one.
module tb_riscv_muldiv_unit;
    logic clk;
    logic rst;
    logic flush;

    int compared   = 0;
    int mismatched = 0;

    string       q32_tag[$];
    logic [31:0] q32_res[$];
    logic [4:0]  q32_rd[$];
    string       q16_tag[$];
    logic [15:0] q16_res[$];
    logic [4:0]  q16_rd[$];

    riscv_muldiv_unit_if #(.XLEN(32)) if32 ();
    riscv_muldiv_unit_if #(.XLEN(16)) if16 ();

    riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut32 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .md_if   (if32.slave)
    );

    riscv_muldiv_unit #(.XLEN(16), .FAST_MUL(1'b0)) dut16 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .md_if   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference semantics of the eight RV32M operations.
    function automatic logic [31:0] model32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        logic signed [31:0] qr;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        qa  = a;
        qb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model32 = '0;
        case (f3)
            3'b000: begin sp = sa * sb; model32 = sp[31:0]; end
            3'b001: begin sp = sa * sb; model32 = sp[63:32]; end
            3'b010: begin sp = sa * $signed({32'b0, b}); model32 = sp[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; model32 = up[63:32]; end
            3'b100: begin
                if (b == 0) model32 = 32'hFFFF_FFFF;
                else if (ovf) model32 = a;
                else begin qr = qa / qb; model32 = qr; end
            end
            3'b101: begin
                if (b == 0) model32 = 32'hFFFF_FFFF;
                else model32 = a / b;
            end
            3'b110: begin
                if (b == 0) model32 = a;
                else if (ovf) model32 = 32'h0;
                else begin qr = qa % qb; model32 = qr; end
            end
            default: begin
                if (b == 0) model32 = a;
                else model32 = a % b;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && if32.out_valid === 1'b1 && if32.out_ready === 1'b1) begin
            if (q32_res.size() == 0) begin
                checkOutput("dut32_unexpected_valid", 64'(1), 64'(0));
            end else begin
                checkOutput({q32_tag[0], "_res"}, 64'(if32.result), 64'(q32_res[0]));
                checkOutput({q32_tag[0], "_rd"}, 64'(if32.rd_out), 64'(q32_rd[0]));
                void'(q32_tag.pop_front());
                void'(q32_res.pop_front());
                void'(q32_rd.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if16.out_valid === 1'b1 && if16.out_ready === 1'b1) begin
            if (q16_res.size() == 0) begin
                checkOutput("dut16_unexpected_valid", 64'(1), 64'(0));
            end else begin
                checkOutput({q16_tag[0], "_res"}, 64'(if16.result), 64'(q16_res[0]));
                checkOutput({q16_tag[0], "_rd"}, 64'(if16.rd_out), 64'(q16_rd[0]));
                void'(q16_tag.pop_front());
                void'(q16_res.pop_front());
                void'(q16_rd.pop_front());
            end
        end
    end

    // Issue one op, record its expectation, check latency and optional backpressure hold.
    task automatic applyStimulus(input bit narrow, input string tag, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_res, input int exp_lat, input int hold);
        int guard;
        int lat;
        if (narrow) begin
            if16.funct3 = f3; if16.op_a = a[15:0]; if16.op_b = b[15:0]; if16.rd_in = rd;
            if16.out_ready = (hold == 0); if16.in_valid = 1'b1;
        end else begin
            if32.funct3 = f3; if32.op_a = a; if32.op_b = b; if32.rd_in = rd;
            if32.out_ready = (hold == 0); if32.in_valid = 1'b1;
        end
        guard = 0;
        while (!(narrow ? if16.in_ready : if32.in_ready) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            checkOutput({tag, "_accept_timeout"}, 64'(1), 64'(0));
            if16.in_valid = 1'b0;
            if32.in_valid = 1'b0;
            return;
        end
        if (narrow) begin
            q16_tag.push_back(tag); q16_res.push_back(exp_res[15:0]); q16_rd.push_back(rd);
        end else begin
            q32_tag.push_back(tag); q32_res.push_back(exp_res); q32_rd.push_back(rd);
        end
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        if32.in_valid = 1'b0;
        lat = 1;
        while (!(narrow ? if16.out_valid : if32.out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                checkOutput({tag, "_hold_valid"}, 64'(narrow ? if16.out_valid : if32.out_valid), 64'(1));
                checkOutput({tag, "_hold_res"}, narrow ? 64'(if16.result) : 64'(if32.result),
                            narrow ? 64'(exp_res[15:0]) : 64'(exp_res));
                checkOutput({tag, "_hold_rd"}, 64'(narrow ? if16.rd_out : if32.rd_out), 64'(rd));
            end
            if16.out_ready = 1'b1;
            if32.out_ready = 1'b1;
            checkOutput({tag, "_done_in_ready"}, 64'(narrow ? if16.in_ready : if32.in_ready), 64'(0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rlat;

        rst = 1'b1;
        flush = 1'b0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1; if32.funct3 = '0; if32.op_a = '0; if32.op_b = '0; if32.rd_in = '0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.funct3 = '0; if16.op_a = '0; if16.op_b = '0; if16.rd_in = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(if32.in_ready), 64'(0));
        checkOutput("rst_out_valid", 64'(if32.out_valid), 64'(0));
        checkOutput("rst_result", 64'(if32.result), 64'(0));
        checkOutput("rst_rd_out", 64'(if32.rd_out), 64'(0));
        checkOutput("rst_busy", 64'(if32.busy), 64'(0));
        checkOutput("rst16_out_valid", 64'(if16.out_valid), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(if32.in_ready), 64'(1));

        applyStimulus(1'b0, "mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1, 0);
        applyStimulus(1'b0, "mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 1, 0);
        applyStimulus(1'b0, "mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1, 0);
        applyStimulus(1'b0, "mulhsu_neg", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 1, 0);
        applyStimulus(1'b0, "div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 0);
        applyStimulus(1'b0, "rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 0);
        applyStimulus(1'b0, "divu_100_7", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 33, 0);
        applyStimulus(1'b0, "remu_100_7", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 33, 0);
        applyStimulus(1'b0, "div_by_0", 3'b100, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 0);
        applyStimulus(1'b0, "remu_by_0", 3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 1, 0);
        applyStimulus(1'b0, "div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 0);
        applyStimulus(1'b0, "rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1, 0);
        applyStimulus(1'b0, "bp_divu", 3'b101, 32'd1000, 32'd9, 5'd13, 32'd111, 33, 5);
        applyStimulus(1'b0, "bp_mul", 3'b000, 32'd6, 32'd9, 5'd14, 32'd54, 1, 5);

        // Kill a DIVU in its tenth cycle; nothing may come out of it.
        if32.funct3 = 3'b101; if32.op_a = 32'd100; if32.op_b = 32'd7; if32.rd_in = 5'd15; if32.in_valid = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        checkOutput("flush_pre_busy", 64'(if32.busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_in_ready", 64'(if32.in_ready), 64'(1));
        checkOutput("flush_busy", 64'(if32.busy), 64'(0));
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (if32.out_valid) seen++; end
        checkOutput("flush_no_valid", 64'(seen), 64'(0));
        applyStimulus(1'b0, "mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd16, 32'd12, 1, 0);

        // Reset in the middle of a divide discards it and clears the outputs.
        if32.funct3 = 3'b100; if32.op_a = 32'd77; if32.op_b = 32'd5; if32.rd_in = 5'd17; if32.in_valid = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 64'(if32.in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_busy", 64'(if32.busy), 64'(0));
        checkOutput("midrst_result", 64'(if32.result), 64'(0));
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (if32.out_valid) seen++; end
        checkOutput("midrst_no_valid", 64'(seen), 64'(0));

        for (int i = 0; i < 20; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if (i == 7) begin rf3 = 3'b110; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            rlat = (!rf3[2] || rb == 0 || (!rf3[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33;
            applyStimulus(1'b0, $sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, 5'($urandom_range(0, 31)),
                          model32(rf3, ra, rb), rlat, 0);
        end

        applyStimulus(1'b1, "x16_mul", 3'b000, 32'h00FF, 32'h0101, 5'd20, 32'h0000_FFFF, 17, 0);
        applyStimulus(1'b1, "x16_div", 3'b100, 32'hFFF8, 32'd3, 5'd21, 32'h0000_FFFE, 17, 0);
        applyStimulus(1'b1, "x16_rem", 3'b110, 32'hFFF8, 32'd3, 5'd22, 32'h0000_FFFE, 17, 0);
        applyStimulus(1'b1, "x16_mulh", 3'b001, 32'hFFFE, 32'h0003, 5'd23, 32'h0000_FFFF, 17, 0);
        applyStimulus(1'b1, "x16_div0", 3'b101, 32'h1234, 32'd0, 5'd24, 32'h0000_FFFF, 1, 0);
        applyStimulus(1'b1, "x16_bp_remu", 3'b111, 32'd1000, 32'd7, 5'd25, 32'd6, 17, 5);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb32_drained", 64'(q32_res.size()), 64'(0));
        checkOutput("sb16_drained", 64'(q16_res.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
